// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - CPU-side status/data bundle of the UART receiver
//  clr_rx        controller -> core  1-cycle strobe: CPU read of RX data
//  Rx_Data       core -> controller  last accepted byte
//  rx_ready      core -> controller  byte available
//  parity_error  core -> controller  parity check result of Rx_Data
//  frame_error   core -> controller  sticky stop-bit-low flag
//  overrun       core -> controller  sticky lost-byte flag
//  busy          core -> controller  receiver mid-frame
interface uart_rx_core_if;
   logic       clr_rx;
   logic [7:0] Rx_Data;
   logic       rx_ready;
   logic       parity_error;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   modport master (
      output clr_rx,
      input  Rx_Data, rx_ready, parity_error, frame_error, overrun, busy
   );

   modport slave (
      input  clr_rx,
      output Rx_Data, rx_ready, parity_error, frame_error, overrun, busy
   );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1/8E1/8O1 UART receiver with ready, parity, frame and overrun status
//  clk   in  system clock, rising edge
//  rst   in  asynchronous active-low reset
//  rx    in  serial line, idle high, asynchronous to clk
//  bus   uart_rx_core_if.slave: clr_rx in; Rx_Data, rx_ready, parity_error,
//        frame_error, overrun, busy out
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx,
   uart_rx_core_if.slave bus
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MID = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t        state, state_nx;
   logic          rx_m, rx_s;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          perr;
   logic [7:0]    data_q;
   logic          ready_q, perr_q, ferr_q, ovr_q;
   logic          mid_start, bit_end, stop_smp;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!rx_s) state_nx = S_START;
         S_START:  if (mid_start) state_nx = rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (bit_end && idx == 3'd7)
                      state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nx = S_STOP;
         S_STOP:   if (bit_end) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // output / strobe decode; after the start-bit midpoint every sample lands
   // a full bit period later, so data, parity and stop all use CNT_END
   always_comb begin
      mid_start = (state == S_START) && (bit_cnt == CNT_MID);
      bit_end   = (bit_cnt == CNT_END);
      stop_smp  = (state == S_STOP) && bit_end;
      bus.busy  = (state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         bit_cnt <= '0;
         idx     <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
         data_q  <= '0;
         ready_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;

         case (state)
            S_IDLE: bit_cnt <= '0;
            S_START: begin
               if (mid_start) begin
                  bit_cnt <= '0;
                  idx     <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  shreg[idx] <= rx_s;
                  idx        <= idx + 3'd1;
                  bit_cnt    <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  perr    <= rx_s ^ (^shreg) ^ (PARITY_ODD != 0);
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) bit_cnt <= '0;
               else         bit_cnt <= bit_cnt + CW'(1);
            end
            default: bit_cnt <= '0;
         endcase

         if (bus.clr_rx) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
         end

         // a load in the same cycle as clr_rx overrides the clear, and the
         // overrun update uses the pre-clear ready flag
         if (stop_smp) begin
            if (rx_s) begin
               data_q  <= shreg;
               perr_q  <= (PARITY_EN != 0) ? perr : 1'b0;
               ready_q <= 1'b1;
               ovr_q   <= ovr_q | ready_q;
            end else begin
               ferr_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.Rx_Data      = data_q;
   assign bus.rx_ready     = ready_q;
   assign bus.parity_error = perr_q;
   assign bus.frame_error  = ferr_q;
   assign bus.overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core (16 clocks/bit, even parity)
module tb_uart_rx_core;

   localparam int CPB   = 16;
   localparam int HALF  = (CPB - 1) / 2;
   localparam int NBITS = 10;
   localparam int PODD  = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx  = 1'b1;

   uart_rx_core_if bus_if();

   uart_rx_core #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (1),
      .PARITY_ODD  (PODD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx (rx),
      .bus(bus_if.slave)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // frame announcements from the stimulus to the model
   int          req_seq = 0;
   int unsigned req_edge = 0;
   logic [7:0]  req_data = '0;
   logic        req_perr = 1'b0;
   logic        req_stop = 1'b1;

   // behavioural model: register-level view of what the CPU should see
   int          seen_seq = 0;
   logic        pend = 1'b0;
   int unsigned pend_edge = 0;
   logic [7:0]  pend_data = '0;
   logic        pend_perr = 1'b0;
   logic        pend_stop = 1'b1;
   logic        hit = 1'b0;
   logic [7:0]  m_data = '0;
   logic        m_rdy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_data = '0; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
         pend = 1'b0;
         seen_seq = req_seq;
      end else begin
         if (req_seq != seen_seq) begin
            seen_seq  = req_seq;
            pend      = 1'b1;
            pend_edge = req_edge;
            pend_data = req_data;
            pend_perr = req_perr;
            pend_stop = req_stop;
         end
         hit = pend && (cyc + 1 == pend_edge);
         if (hit) pend = 1'b0;
         if (hit && pend_stop) begin
            m_ovr  = m_ovr | m_rdy;
            m_rdy  = 1'b1;
            m_data = pend_data;
            m_perr = pend_perr;
            if (bus_if.clr_rx) m_ferr = 1'b0;
         end else begin
            if (bus_if.clr_rx) begin
               m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
            end
            if (hit) m_ferr = 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // pin-level frame: idle gap, start, 8 data LSB-first, parity, stop
   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                             input logic clr_at_load, output int unsigned e0);
      int unsigned d_edge;
      repeat (CPB) @(posedge clk);
      #1;
      e0 = cyc;
      rx = 1'b0;
      // rx first seen at e0+1, 2 sync stages, half-bit to the start midpoint,
      // then NBITS whole bits to the stop midpoint, result visible that edge
      d_edge   = e0 + 4 + HALF + NBITS * CPB;
      req_data = d;
      req_perr = (($countones({d, pbit}) % 2) != PODD);
      req_stop = stop;
      req_edge = d_edge;
      req_seq++;
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(posedge clk);
         #1 rx = d[i];
      end
      repeat (CPB) @(posedge clk);
      #1 rx = pbit;
      repeat (CPB) @(posedge clk);
      #1 rx = stop;
      for (int c = 0; c < CPB; c++) begin
         @(posedge clk);
         #1;
         if (clr_at_load) bus_if.clr_rx = (cyc == d_edge - 1);
      end
      rx = 1'b1;
      bus_if.clr_rx = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #1 bus_if.clr_rx = 1'b1;
      @(posedge clk);
      #1 bus_if.clr_rx = 1'b0;
   endtask

   int unsigned rise_cyc = 0;
   logic        prev_rdy = 1'b0;
   int unsigned e0;

   initial begin
      bus_if.clr_rx = 1'b0;

      fork
         forever begin
            @(negedge clk);
            chk("Rx_Data",      {24'd0, bus_if.Rx_Data}, {24'd0, m_data});
            chk("rx_ready",     {31'd0, bus_if.rx_ready}, {31'd0, m_rdy});
            chk("parity_error", {31'd0, bus_if.parity_error}, {31'd0, m_perr});
            chk("frame_error",  {31'd0, bus_if.frame_error}, {31'd0, m_ferr});
            chk("overrun",      {31'd0, bus_if.overrun}, {31'd0, m_ovr});
            if (bus_if.rx_ready && !prev_rdy) rise_cyc = cyc;
            prev_rdy = bus_if.rx_ready;
         end
      join_none

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data",  {24'd0, bus_if.Rx_Data}, 32'h00);
      chk("rst_ready", {31'd0, bus_if.rx_ready}, 32'd0);
      chk("rst_flags", {29'd0, bus_if.parity_error, bus_if.frame_error, bus_if.overrun}, 32'd0);
      chk("rst_busy",  {31'd0, bus_if.busy}, 32'd0);
      rst = 1'b1;

      // 1: good frame, latency pinned to the sample schedule
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, e0);
      chk("t1_data",    {24'd0, bus_if.Rx_Data}, 32'hA5);
      chk("t1_ready",   {31'd0, bus_if.rx_ready}, 32'd1);
      chk("t1_perr",    {31'd0, bus_if.parity_error}, 32'd0);
      chk("t1_latency", rise_cyc - e0, 32'd171);
      chk("t1_idle",    {31'd0, bus_if.busy}, 32'd0);
      pulse_clr();
      chk("t1_clr",     {31'd0, bus_if.rx_ready}, 32'd0);

      // 2: wrong parity bit for even parity
      send_frame(8'h3C, 1'b1, 1'b1, 1'b0, e0);
      chk("t2_data",  {24'd0, bus_if.Rx_Data}, 32'h3C);
      chk("t2_perr",  {31'd0, bus_if.parity_error}, 32'd1);
      chk("t2_ready", {31'd0, bus_if.rx_ready}, 32'd1);
      pulse_clr();

      // 3: 6-cycle glitch is a false start
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("t3_busy", {31'd0, bus_if.busy}, 32'd1);
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("t3_idle",  {31'd0, bus_if.busy}, 32'd0);
      chk("t3_ready", {31'd0, bus_if.rx_ready}, 32'd0);
      chk("t3_data",  {24'd0, bus_if.Rx_Data}, 32'h3C);
      chk("t3_ferr",  {31'd0, bus_if.frame_error}, 32'd0);

      // 4: overrun
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, e0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, e0);
      chk("t4_data",    {24'd0, bus_if.Rx_Data}, 32'h22);
      chk("t4_overrun", {31'd0, bus_if.overrun}, 32'd1);
      chk("t4_perr",    {31'd0, bus_if.parity_error}, 32'd0);
      pulse_clr();
      chk("t4_clr_ready",   {31'd0, bus_if.rx_ready}, 32'd0);
      chk("t4_clr_overrun", {31'd0, bus_if.overrun}, 32'd0);

      // 5: stop bit low
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, e0);
      chk("t5_ferr",  {31'd0, bus_if.frame_error}, 32'd1);
      chk("t5_ready", {31'd0, bus_if.rx_ready}, 32'd0);
      chk("t5_data",  {24'd0, bus_if.Rx_Data}, 32'h22);
      repeat (20) @(posedge clk);
      pulse_clr();
      chk("t5_clr_ferr", {31'd0, bus_if.frame_error}, 32'd0);

      // 6: clr_rx coincident with a load while a byte is pending
      send_frame(8'h42, 1'b0, 1'b1, 1'b0, e0);
      send_frame(8'h77, 1'b0, 1'b1, 1'b1, e0);
      chk("t6_ready",   {31'd0, bus_if.rx_ready}, 32'd1);
      chk("t6_data",    {24'd0, bus_if.Rx_Data}, 32'h77);
      chk("t6_overrun", {31'd0, bus_if.overrun}, 32'd1);

      // asynchronous reset in the middle of the data bits
      repeat (CPB) @(posedge clk);
      #1 rx = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      #1 chk("rm_busy_before", {31'd0, bus_if.busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rm_data",  {24'd0, bus_if.Rx_Data}, 32'h00);
      chk("rm_ready", {31'd0, bus_if.rx_ready}, 32'd0);
      chk("rm_flags", {29'd0, bus_if.parity_error, bus_if.frame_error, bus_if.overrun}, 32'd0);
      chk("rm_busy",  {31'd0, bus_if.busy}, 32'd0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // reception resumes after reset
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, e0);
      chk("rec_data",  {24'd0, bus_if.Rx_Data}, 32'h5A);
      chk("rec_ready", {31'd0, bus_if.rx_ready}, 32'd1);

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
